// File: rtl/lsu_pkg.sv
// lsu_pkg
// Shared LSU definitions: queue sizes and index widths, the per-tag load table entry,
// and the cache request slot layout used by lsu_mem_arbiter.
package lsu_pkg;

    localparam int LDQ_ENTRIES = 16;
    localparam int SDQ_ENTRIES = 16;
    localparam int LDQ_IDX_W   = $clog2(LDQ_ENTRIES);
    localparam int SDQ_IDX_W   = $clog2(SDQ_ENTRIES);

    // One in-flight load: the LDQ entry its response must be routed back to.
    typedef struct packed {
        logic                 busy;
        logic [LDQ_IDX_W-1:0] ldqIdx;
    } ldq_entry_t;

    // Payload of the registered cache request slot. The tag is held next to it in the
    // arbiter because its width follows the MAX_OUTSTANDING parameter.
    typedef struct packed {
        logic        vld;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mem_req_t;

endpackage

// File: rtl/lsu_tag_table.sv
// lsu_tag_table
// Tracks which load tags are in flight and which LDQ entry each belongs to.
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_alloc, i_alloc_ldq_idx  claim o_alloc_tag (lowest free) for this LDQ index
//   o_alloc_tag, o_full    lowest free tag and all-busy flag, from registered state only
//   i_resp_vld, i_resp_tag response lookup
//   o_resp_hit, o_resp_ldq_idx  response matches a busy tag; that tag's LDQ index
//   o_resp_spurious        response for a tag that is not in flight
module lsu_tag_table
    import lsu_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int TAG_W           = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_alloc,
    input  logic [LDQ_IDX_W-1:0] i_alloc_ldq_idx,
    output logic [TAG_W-1:0]     o_alloc_tag,
    output logic                 o_full,
    input  logic                 i_resp_vld,
    input  logic [TAG_W-1:0]     i_resp_tag,
    output logic                 o_resp_hit,
    output logic                 o_resp_spurious,
    output logic [LDQ_IDX_W-1:0] o_resp_ldq_idx
);

    ldq_entry_t r_table [MAX_OUTSTANDING];
    ldq_entry_t w_respEntry;
    logic       w_found;

    // Priority encoder over the start-of-cycle state, so a tag freed by a response this
    // cycle cannot be reallocated until the next cycle.
    always_comb begin
        o_alloc_tag = '0;
        w_found     = 1'b0;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (!r_table[i].busy && !w_found) begin
                o_alloc_tag = TAG_W'(i);
                w_found     = 1'b1;
            end
        end
        o_full = !w_found;
    end

    always_comb begin
        w_respEntry     = r_table[i_resp_tag];
        o_resp_hit      = i_resp_vld && w_respEntry.busy;
        o_resp_spurious = i_resp_vld && !w_respEntry.busy;
        o_resp_ldq_idx  = w_respEntry.ldqIdx;
    end

    // A response and an allocation never target the same tag: the allocated tag is free,
    // the responding one is busy.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_table[i] <= '0;
            end
        end else begin
            if (o_resp_hit) begin
                r_table[i_resp_tag] <= '0;
            end
            if (i_alloc) begin
                r_table[o_alloc_tag] <= '{busy: 1'b1, ldqIdx: i_alloc_ldq_idx};
            end
        end
    end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter
// Shares the data-cache port between LDQ load issue and SDQ store commit. Loads win
// unless a store has lost STARVE_LIMIT times in a row (only when LSU_ARB_STARVE_EN is
// defined). A single registered slot drives the cache request.
// Ports:
//   i_clk, i_rst                         clock, asynchronous active-high reset
//   i_ld_req_* / o_ld_req_rdy            load request (addr, LDQ index)
//   i_st_req_* / o_st_req_rdy            store commit (addr, data, byte mask)
//   o_mem_req_* / i_mem_req_rdy          cache request slot
//   i_mem_resp_*                         load response from cache (always accepted)
//   o_ld_resp_*                          load data back to the LDQ, one cycle later
//   o_err_spurious_resp                  sticky: response for a tag not in flight
// Macro: LSU_ARB_STARVE_EN enables the store starvation counter.
module lsu_mem_arbiter
    import lsu_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int LDQ_IDX_W       = lsu_pkg::LDQ_IDX_W,
    parameter int STARVE_LIMIT    = 8,
    localparam int TAG_W          = $clog2(MAX_OUTSTANDING)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ld_req_vld,
    output logic                 o_ld_req_rdy,
    input  logic [31:0]          i_ld_req_addr,
    input  logic [LDQ_IDX_W-1:0] i_ld_req_ldq_idx,
    input  logic                 i_st_req_vld,
    output logic                 o_st_req_rdy,
    input  logic [31:0]          i_st_req_addr,
    input  logic [31:0]          i_st_req_data,
    input  logic [3:0]           i_st_req_wmask,
    output logic                 o_mem_req_vld,
    input  logic                 i_mem_req_rdy,
    output logic                 o_mem_req_we,
    output logic [31:0]          o_mem_req_addr,
    output logic [31:0]          o_mem_req_wdata,
    output logic [3:0]           o_mem_req_wmask,
    output logic [TAG_W-1:0]     o_mem_req_tag,
    input  logic                 i_mem_resp_vld,
    input  logic [TAG_W-1:0]     i_mem_resp_tag,
    input  logic [31:0]          i_mem_resp_data,
    output logic                 o_ld_resp_vld,
    output logic [LDQ_IDX_W-1:0] o_ld_resp_ldq_idx,
    output logic [31:0]          o_ld_resp_data,
    output logic                 o_err_spurious_resp
);

    if (MAX_OUTSTANDING < 2 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_badOutstanding
        $error("lsu_mem_arbiter: MAX_OUTSTANDING must be a power of 2 and at least 2");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_badLimit
        $error("lsu_mem_arbiter: STARVE_LIMIT must be within 1..255");
    end

    mem_req_t               r_slot;
    logic [TAG_W-1:0]       r_slotTag;
    logic                   r_ldRespVld;
    logic [LDQ_IDX_W-1:0]   r_ldRespIdx;
    logic [31:0]            r_ldRespData;
    logic                   r_errSpurious;

    logic                   w_slotFree;
    logic                   w_ldElig;
    logic                   w_stElig;
    logic                   w_forceSt;
    logic                   w_ldGrant;
    logic                   w_stGrant;
    logic [TAG_W-1:0]       w_allocTag;
    logic                   w_tagFull;
    logic                   w_respHit;
    logic                   w_respSpurious;
    logic [LDQ_IDX_W-1:0]   w_respLdqIdx;

    lsu_tag_table #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .TAG_W           (TAG_W)
    ) u_tagTable (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_alloc         (w_ldGrant),
        .i_alloc_ldq_idx (i_ld_req_ldq_idx),
        .o_alloc_tag     (w_allocTag),
        .o_full          (w_tagFull),
        .i_resp_vld      (i_mem_resp_vld),
        .i_resp_tag      (i_mem_resp_tag),
        .o_resp_hit      (w_respHit),
        .o_resp_spurious (w_respSpurious),
        .o_resp_ldq_idx  (w_respLdqIdx)
    );

`ifdef LSU_ARB_STARVE_EN
    logic [7:0] r_starveCnt;

    assign w_forceSt = (r_starveCnt == 8'(STARVE_LIMIT));

    // Counts consecutive losses of a waiting store; saturates so the force stays on
    // until the store finally goes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_starveCnt <= '0;
        end else if (w_stGrant) begin
            r_starveCnt <= '0;
        end else if (i_st_req_vld && !w_forceSt) begin
            r_starveCnt <= r_starveCnt + 8'd1;
        end
    end
`else
    assign w_forceSt = 1'b0;
`endif

    // Grants are suppressed during reset so the ready outputs read 0 immediately.
    always_comb begin
        w_slotFree = !r_slot.vld || i_mem_req_rdy;
        w_ldElig   = !i_rst && i_ld_req_vld && w_slotFree && !w_tagFull;
        w_stElig   = !i_rst && i_st_req_vld && w_slotFree;
        w_ldGrant  = w_ldElig && !(w_stElig && w_forceSt);
        w_stGrant  = w_stElig && !w_ldGrant;
    end

    assign o_ld_req_rdy = w_ldGrant;
    assign o_st_req_rdy = w_stGrant;

    // The slot is only rewritten when the cache takes (or never had) its contents.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_slot    <= '0;
            r_slotTag <= '0;
        end else if (w_slotFree) begin
            if (w_ldGrant) begin
                r_slot    <= '{vld: 1'b1, we: 1'b0, addr: i_ld_req_addr, wdata: 32'd0, wmask: 4'd0};
                r_slotTag <= w_allocTag;
            end else if (w_stGrant) begin
                r_slot    <= '{vld: 1'b1, we: 1'b1, addr: i_st_req_addr,
                               wdata: i_st_req_data, wmask: i_st_req_wmask};
                r_slotTag <= '0;
            end else begin
                r_slot    <= '0;
                r_slotTag <= '0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ldRespVld   <= 1'b0;
            r_ldRespIdx   <= '0;
            r_ldRespData  <= '0;
            r_errSpurious <= 1'b0;
        end else begin
            r_ldRespVld <= w_respHit;
            if (w_respHit) begin
                r_ldRespIdx  <= w_respLdqIdx;
                r_ldRespData <= i_mem_resp_data;
            end
            if (w_respSpurious) begin
                r_errSpurious <= 1'b1;
            end
        end
    end

    assign o_mem_req_vld       = r_slot.vld;
    assign o_mem_req_we        = r_slot.we;
    assign o_mem_req_addr      = r_slot.addr;
    assign o_mem_req_wdata     = r_slot.wdata;
    assign o_mem_req_wmask     = r_slot.wmask;
    assign o_mem_req_tag       = r_slotTag;
    assign o_ld_resp_vld       = r_ldRespVld;
    assign o_ld_resp_ldq_idx   = r_ldRespIdx;
    assign o_ld_resp_data      = r_ldRespData;
    assign o_err_spurious_resp = r_errSpurious;

endmodule

// File: doc/lsu_mem_arbiter.md
# lsu_mem_arbiter

Shares the single data-cache port between the load data queue issue path and the store data queue commit path inside the LSU. Loads carry a tag so their responses can return out of order; stores are fire-and-forget. Arbitration gives loads priority, with a starvation limit for stores. One registered output slot decouples grant decisions from cache backpressure.

## Interface
- `MAX_OUTSTANDING`, 4: number of in-flight loads, which is also the tag count; power of 2, ≥2.
- `LDQ_IDX_W`, `$clog2(LDQ_ENTRIES)` from the package: LDQ index width.
- `STARVE_LIMIT`, 8: cycles a pending store may lose before it is forced; range 1..255.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `ld_req_vld` in 1, `ld_req_rdy` out 1, `ld_req_addr` in 32, `ld_req_ldq_idx` in LDQ_IDX_W: load request; valid/ready handshake.
- `st_req_vld` in 1, `st_req_rdy` out 1, `st_req_addr` in 32, `st_req_data` in 32, `st_req_wmask` in 4: store commit request.
- `mem_req_vld` out 1, `mem_req_rdy` in 1, `mem_req_we` out 1, `mem_req_addr` out 32, `mem_req_wdata` out 32, `mem_req_wmask` out 4, `mem_req_tag` out TAG_W: cache request.
- `mem_resp_vld` in 1, `mem_resp_tag` in TAG_W, `mem_resp_data` in 32: load response from the cache. Always accepted; there is no ready signal.
- `ld_resp_vld` out 1, `ld_resp_ldq_idx` out LDQ_IDX_W, `ld_resp_data` out 32: load data returned to the LDQ.
- `err_spurious_resp` out 1: sticky flag, set when a response arrives for a tag that is not outstanding.
- TAG_W = `$clog2(MAX_OUTSTANDING)`.

## Operation
- **Output slot.** One register holds {vld, we, addr, wdata, wmask, tag}. The slot is free when `!mem_req_vld || mem_req_rdy`.
- **Grant eligibility.** A load is eligible when `ld_req_vld`, the slot is free, and a free tag exists. A store is eligible when `st_req_vld` and the slot is free.
- **Priority.** Loads win over stores unless `starve_cnt == STARVE_LIMIT`, in which case the store wins.
- **Ready outputs.** `ld_req_rdy` and `st_req_rdy` are combinational and are asserted only for the requester that wins this cycle. The other requester sees rdy=0.
- **Tag table.** Each of the MAX_OUTSTANDING entries holds {busy, ldq_idx}.
  - A load grant allocates the lowest-index free tag, stores `ld_req_ldq_idx` in it, and places that tag in the slot.
  - Store slots drive `mem_req_tag` = 0 and `mem_req_wdata`/`mem_req_wmask` from the request. Load slots drive wdata = 0 and wmask = 0.
- **Response.** When `mem_resp_vld` arrives and the tag is busy:
  - The entry is cleared.
  - Next cycle, `ld_resp_vld` = 1, `ld_resp_ldq_idx` = the entry's ldq_idx, `ld_resp_data` = `mem_resp_data`.
  - If the tag is not busy, the response is dropped and `err_spurious_resp` is set.
- **Starvation counter.** `starve_cnt` is 8 bits. It increments, saturating at STARVE_LIMIT, on every cycle with `st_req_vld && !st_req_rdy`. It clears when a store is granted.

## Timing
- **Reset values.** All outputs are 0. The tag table is all-free and `starve_cnt` = 0. Reset mid-operation discards in-flight tags and the slot contents; responses that arrive after reset count as spurious.
- **Grant latency.** A grant at edge N gives `mem_req_vld` = 1 in cycle N+1. Back-to-back grants sustain one request per cycle while `mem_req_rdy` = 1.
- **Backpressure.** While `mem_req_rdy` = 0, the slot contents hold stable and both rdy outputs are 0.
- **Response latency.** Response to `ld_resp_vld` is 1 cycle. `ld_resp_vld` is a single-cycle pulse per response.
- **No same-cycle tag bypass.** Free-tag availability uses the table state at the start of the cycle. A response freeing the only busy tag does not enable a load grant in the same cycle; the grant can happen next cycle.
- **Same-tag response.** A response and a grant for the same tag cannot coincide, because the tag is busy.
- **Full table.** With all tags busy, `ld_req_rdy` = 0 and stores are still granted.

## Configuration
- `LSU_ARB_STARVE_EN` defined: the starvation counter and forced store priority are present as described above.
- Undefined: fixed load priority, no counter logic, STARVE_LIMIT is ignored, and stores can starve indefinitely.

## Structure
- **Shared package `lsu_pkg`:** LDQ_ENTRIES, the SDQ/LDQ index widths, the `ldq_entry_t` typedef, and a `mem_req_t` struct for the slot.
- **Sub-module `lsu_tag_table`:** allocate (lowest free index), free on response, lookup by tag, full flag, spurious detection.
- The arbiter, slot register and starvation counter live in the top module.

## Test plan
- **Basic load.** ld_req addr 0x100, idx 3, cache rdy=1, response tag 0 data 0xDEADBEEF two cycles later → `mem_req` we=0 addr 0x100 tag 0 one cycle after the grant; then `ld_resp_vld` with idx 3, data 0xDEADBEEF one cycle after the response.
- **Table full.** 4 loads granted with no responses → tags 0,1,2,3 allocated; the 5th load sees rdy=0. A response for tag 2 → the next load gets tag 2 one cycle later.
- **Starvation.** With the macro defined, continuous loads plus a store pending 8 cycles → store granted on cycle 9 and counter cleared. With the macro undefined → the store is never granted while loads persist.
- **Backpressure.** `mem_req_rdy` = 0 for 5 cycles with a slot loaded → addr, data and tag stable, both rdy = 0; rdy returns 1 when `mem_req_rdy` = 1.
- **Out-of-order responses and spurious detection.** Responses for tags 1 then 0 → LDQ indices routed correctly. Then a response for an idle tag → `err_spurious_resp` latches 1, no `ld_resp_vld`.
- **Async reset mid-flight.** Assert `rst` asynchronously mid-cycle with 2 tags busy → all outputs 0 immediately, table free. A later response for tag 0 → flagged spurious.
